// File: rtl/seq_fetch.sv
// Program-fetch controller for the Seq sequencer: fetches 12-bit words from a
// 1-cycle synchronous program memory and issues them to Seq. Optional watchdog: SEQ_FETCH_WATCHDOG_EN.
module seq_fetch #(
    parameter logic [7:0] StartAddr = 8'h00,
    parameter logic [7:0] StepLimit = 8'hFF
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic        abort,
    input  logic [11:0] mem_data,
    input  logic [7:0]  next,
    output logic [7:0]  mem_addr,
    output logic        mem_rd,
    output logic [11:0] inst,
    output logic        inst_en,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [7:0]  count
);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        DECODE,
        ISSUE,
        SETTLE
    } state_t;

    localparam logic [3:0] OpHalt = 4'hF;

    state_t     state;
    logic [7:0] pc;
    logic       is_halt;
    logic       run_accept;

    assign is_halt    = (mem_data[11:8] == OpHalt);
    assign run_accept = (state == IDLE) && start && !abort;

    // The address bus simply follows pc so it rests at StartAddr out of reset.
    assign mem_addr = pc;
    assign mem_rd   = (state == FETCH);
    assign busy     = (state != IDLE);

`ifdef SEQ_FETCH_WATCHDOG_EN
    logic wd_trip;
    assign wd_trip = (state == DECODE) && !abort && !is_halt && (count == StepLimit);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            error <= 1'b0;
        end else if (run_accept) begin
            error <= 1'b0;
        end else if (wd_trip) begin
            error <= 1'b1;
        end
    end
`else
    logic unused_step_limit;
    assign unused_step_limit = ^StepLimit;
    assign error = 1'b0;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            pc      <= StartAddr;
            inst    <= '0;
            inst_en <= 1'b0;
            done    <= 1'b0;
            count   <= '0;
        end else begin
            inst_en <= 1'b0;
            done    <= 1'b0;
            case (state)
                IDLE: begin
                    if (run_accept) begin
                        state <= FETCH;
                        pc    <= StartAddr;
                        count <= '0;
                    end
                end
                FETCH: begin
                    state <= abort ? IDLE : DECODE;
                end
                DECODE: begin
                    // Abort outranks a halt word: no done pulse on an aborted run.
                    if (abort) begin
                        state <= IDLE;
                    end else if (is_halt) begin
                        done  <= 1'b1;
                        state <= IDLE;
`ifdef SEQ_FETCH_WATCHDOG_EN
                    end else if (count == StepLimit) begin
                        state <= IDLE;
`endif
                    end else begin
                        inst    <= mem_data;
                        inst_en <= 1'b1;
                        state   <= ISSUE;
                    end
                end
                ISSUE: begin
`ifdef SEQ_FETCH_WATCHDOG_EN
                    if (count != StepLimit) begin
                        count <= count + 8'd1;
                    end
`else
                    count <= count + 8'd1;
`endif
                    state <= abort ? IDLE : SETTLE;
                end
                SETTLE: begin
                    if (abort) begin
                        state <= IDLE;
                    end else begin
                        pc    <= next;
                        state <= FETCH;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_fetch.sv
// Scoreboard bench for seq_fetch: a program memory and a small Seq model
// (increment, or jump on JXI) drive the DUT; fetch addresses and issued words are checked.
module tb_seq_fetch;

    localparam logic [7:0] START  = 8'h00;
    localparam logic [3:0] OP_JXI = 4'h8;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic        abort;
    logic [11:0] mem_data = '0;
    logic [7:0]  next = '0;
    logic [7:0]  mem_addr;
    logic        mem_rd;
    logic [11:0] inst;
    logic        inst_en;
    logic        busy;
    logic        done;
    logic        error;
    logic [7:0]  count;

    logic [11:0] mem [0:255];
    logic [7:0]  seq_addr = '0;

    logic [7:0]  exp_addr[$];
    logic [11:0] exp_inst[$];

    int n_checks = 0;
    int n_fail   = 0;

    seq_fetch #(
        .StartAddr(START),
        .StepLimit(8'd4)
    ) dut (
        .clock   (clock),
        .reset   (reset),
        .start   (start),
        .abort   (abort),
        .mem_data(mem_data),
        .next    (next),
        .mem_addr(mem_addr),
        .mem_rd  (mem_rd),
        .inst    (inst),
        .inst_en (inst_en),
        .busy    (busy),
        .done    (done),
        .error   (error),
        .count   (count)
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (mem_rd) mem_data <= mem[mem_addr];
    end

    // Seq model: next is the jump target for JXI, otherwise the fetched address + 1.
    always @(posedge clock) begin
        if (mem_rd) seq_addr <= mem_addr;
        if (inst_en) next <= (inst[11:8] == OP_JXI) ? inst[7:0] : seq_addr + 8'd1;
    end

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) mem[i] = 12'hF00;
    endtask

    task automatic load_halt_prog();
        clear_mem();
        mem[0] = 12'h1FA;
        mem[1] = 12'h000;
        mem[2] = 12'h111;
        mem[3] = 12'hF00;
    endtask

    task automatic build_expected(input int n_fetch, input int n_issue);
        logic [7:0]  a;
        logic [11:0] w;
        int          issued;
        exp_addr.delete();
        exp_inst.delete();
        a = START;
        issued = 0;
        for (int i = 0; i < n_fetch; i++) begin
            exp_addr.push_back(a);
            w = mem[a];
            if (w[11:8] == 4'hF) break;
            if (issued < n_issue) begin
                exp_inst.push_back(w);
                issued++;
            end
            a = (w[11:8] == OP_JXI) ? w[7:0] : a + 8'd1;
        end
    endtask

    // Pulses start, then samples each cycle (cycle 1 = first FETCH) until busy drops.
    task automatic run_prog(input int start_extra, input int abort_at, input int budget,
                            output int issued, output int end_cyc, output logic done_end,
                            output int first_issue);
        int          prev;
        bit          fin;
        logic [7:0]  a;
        logic [11:0] w;
        issued = 0; end_cyc = -1; done_end = 1'b0; first_issue = -1; prev = -1; fin = 0;
        @(negedge clock);
        start = 1'b1;
        @(posedge clock);
        #1 start = 1'b0;
        for (int cyc = 1; cyc <= budget && !fin; cyc++) begin
            @(negedge clock);
            abort = (cyc == abort_at);
            start = (cyc == start_extra);
            if (mem_rd) begin
                n_checks++;
                if (exp_addr.size() == 0) begin
                    n_fail++;
                    $display("FAIL fetch_extra: mem_addr=%h in cycle %0d, required no fetch", mem_addr, cyc);
                end else begin
                    a = exp_addr.pop_front();
                    if (mem_addr !== a) begin
                        n_fail++;
                        $display("FAIL fetch_addr: mem_addr=%h, required %h", mem_addr, a);
                    end
                end
            end
            if (inst_en) begin
                issued++;
                if (first_issue < 0) first_issue = cyc;
                if (prev >= 0) begin
                    n_checks++;
                    if (cyc - prev != 4) begin
                        n_fail++;
                        $display("FAIL issue_spacing: %0d cycles, required 4", cyc - prev);
                    end
                end
                prev = cyc;
                n_checks++;
                if (exp_inst.size() == 0) begin
                    n_fail++;
                    $display("FAIL inst_extra: inst=%h issued, required none", inst);
                end else begin
                    w = exp_inst.pop_front();
                    if (inst !== w) begin
                        n_fail++;
                        $display("FAIL inst_word: inst=%h, required %h", inst, w);
                    end
                end
            end
            if (!busy) begin
                end_cyc  = cyc;
                done_end = done;
                fin      = 1;
            end
        end
        abort = 1'b0;
        start = 1'b0;
        n_checks++;
        if (!fin) begin
            n_fail++;
            $display("FAIL run_timeout: busy=%b after %0d cycles, required 0", busy, budget);
        end
        n_checks++;
        if (exp_inst.size() != 0 || exp_addr.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_left: %0d inst, %0d addr pending, required 0",
                     exp_inst.size(), exp_addr.size());
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; abort = 1'b0;
        clear_mem();
        repeat (2) @(posedge clock);
        @(negedge clock);
        n_checks++;
        if ({busy, inst_en, mem_rd, done, error} !== 5'b0 || mem_addr !== START ||
            inst !== 12'h000 || count !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_values: busy=%b inst_en=%b mem_rd=%b done=%b error=%b addr=%h inst=%h count=%h, required all 0, addr=%h",
                     busy, inst_en, mem_rd, done, error, mem_addr, inst, count, START);
        end
        reset = 1'b0;
    endtask

    task automatic test_halt();
        int issued, end_cyc, first;
        logic done_end;
        load_halt_prog();
        build_expected(4, 3);
        run_prog(0, 0, 40, issued, end_cyc, done_end, first);
        n_checks++;
        if (issued != 3) begin n_fail++; $display("FAIL halt_issued: %0d, required 3", issued); end
        n_checks++;
        if (first != 3) begin n_fail++; $display("FAIL halt_latency: first inst_en cycle %0d, required 3", first); end
        n_checks++;
        if (end_cyc != 15 || done_end !== 1'b1) begin
            n_fail++;
            $display("FAIL halt_done: idle cycle %0d done=%b, required 15 and 1", end_cyc, done_end);
        end
        n_checks++;
        if (count !== 8'd3 || error !== 1'b0) begin
            n_fail++;
            $display("FAIL halt_count: count=%h error=%b, required 03 and 0", count, error);
        end
        @(negedge clock);
        n_checks++;
        if (done !== 1'b0) begin n_fail++; $display("FAIL halt_done_pulse: done=%b, required 0", done); end
    endtask

    task automatic test_jump();
        int issued, end_cyc, first;
        logic done_end;
        clear_mem();
        mem[8'h00] = 12'h81A;
        mem[8'h1A] = 12'h133;
        mem[8'h1B] = 12'hF00;
        build_expected(3, 2);
        run_prog(2, 0, 40, issued, end_cyc, done_end, first);
        n_checks++;
        if (issued != 2 || end_cyc != 11 || done_end !== 1'b1 || count !== 8'd2) begin
            n_fail++;
            $display("FAIL jump_run: issued=%0d end=%0d done=%b count=%h, required 2 11 1 02",
                     issued, end_cyc, done_end, count);
        end
    endtask

    task automatic test_abort();
        int issued, end_cyc, first;
        logic done_end;
        load_halt_prog();
        build_expected(2, 1);
        run_prog(0, 6, 40, issued, end_cyc, done_end, first);
        n_checks++;
        if (issued != 1 || end_cyc != 7 || done_end !== 1'b0 || count !== 8'd1) begin
            n_fail++;
            $display("FAIL abort_decode: issued=%0d end=%0d done=%b count=%h, required 1 7 0 01",
                     issued, end_cyc, done_end, count);
        end
        build_expected(2, 2);
        run_prog(0, 7, 40, issued, end_cyc, done_end, first);
        n_checks++;
        if (issued != 2 || end_cyc != 8 || done_end !== 1'b0 || count !== 8'd2) begin
            n_fail++;
            $display("FAIL abort_issue: issued=%0d end=%0d done=%b count=%h, required 2 8 0 02",
                     issued, end_cyc, done_end, count);
        end
    endtask

    task automatic test_reset_mid_run();
        int issued, end_cyc, first;
        logic done_end;
        load_halt_prog();
        @(negedge clock);
        start = 1'b1;
        @(posedge clock);
        #1 start = 1'b0;
        repeat (3) @(negedge clock);
        n_checks++;
        if (inst_en !== 1'b1) begin n_fail++; $display("FAIL midrun_issue: inst_en=%b, required 1", inst_en); end
        reset = 1'b1;
        #1;
        n_checks++;
        if ({busy, inst_en, mem_rd, done, error} !== 5'b0 || mem_addr !== START ||
            inst !== 12'h000 || count !== 8'h00) begin
            n_fail++;
            $display("FAIL midrun_reset: busy=%b inst_en=%b mem_rd=%b done=%b error=%b addr=%h inst=%h count=%h, required all 0",
                     busy, inst_en, mem_rd, done, error, mem_addr, inst, count);
        end
        @(negedge clock);
        reset = 1'b0;
        build_expected(4, 3);
        run_prog(0, 0, 40, issued, end_cyc, done_end, first);
        n_checks++;
        if (issued != 3 || done_end !== 1'b1) begin
            n_fail++;
            $display("FAIL midrun_rerun: issued=%0d done=%b, required 3 and 1", issued, done_end);
        end
    endtask

    task automatic test_collision();
        @(negedge clock);
        start = 1'b1;
        abort = 1'b1;
        @(posedge clock);
        #1 start = 1'b0;
        abort = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            n_checks++;
            if (busy !== 1'b0 || mem_rd !== 1'b0) begin
                n_fail++;
                $display("FAIL collision_idle: busy=%b mem_rd=%b, required 0 0", busy, mem_rd);
            end
        end
    endtask

`ifdef SEQ_FETCH_WATCHDOG_EN
    task automatic test_watchdog();
        int issued, end_cyc, first;
        logic done_end;
        clear_mem();
        mem[0] = 12'h800;
        build_expected(5, 4);
        run_prog(0, 0, 60, issued, end_cyc, done_end, first);
        n_checks++;
        if (issued != 4 || end_cyc != 19 || done_end !== 1'b0 || error !== 1'b1 || count !== 8'd4) begin
            n_fail++;
            $display("FAIL watchdog_trip: issued=%0d end=%0d done=%b error=%b count=%h, required 4 19 0 1 04",
                     issued, end_cyc, done_end, error, count);
        end
        repeat (3) @(negedge clock);
        n_checks++;
        if (error !== 1'b1) begin n_fail++; $display("FAIL watchdog_sticky: error=%b, required 1", error); end
        mem[0] = 12'hF00;
        build_expected(1, 0);
        run_prog(0, 0, 20, issued, end_cyc, done_end, first);
        n_checks++;
        if (error !== 1'b0 || done_end !== 1'b1) begin
            n_fail++;
            $display("FAIL watchdog_clear: error=%b done=%b, required 0 1", error, done_end);
        end
    endtask
`else
    task automatic test_count_wrap();
        int issued, end_cyc, first;
        logic done_end;
        clear_mem();
        mem[0] = 12'h800;
        build_expected(257, 257);
        run_prog(0, 1027, 1100, issued, end_cyc, done_end, first);
        n_checks++;
        if (issued != 257 || count !== 8'h01 || error !== 1'b0 || done_end !== 1'b0) begin
            n_fail++;
            $display("FAIL count_wrap: issued=%0d count=%h error=%b done=%b, required 257 01 0 0",
                     issued, count, error, done_end);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_halt();
        test_jump();
        test_abort();
        test_reset_mid_run();
        test_collision();
`ifdef SEQ_FETCH_WATCHDOG_EN
        test_watchdog();
`else
        test_count_wrap();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation exceeded 200000 time units");
        $fatal(1, "bench timed out");
    end

endmodule
